stall_pipe_regs: RTL
====================

// Module: stall_pipe_regs
// PURPOSE
//  Front-end pipeline state that acts on the load-use hazard unit's EX_Bubble, PC_Write and IFID_Write.
//  Holds the PC, the IF/ID latch and the ID/EX latch. Injects bubbles, holds stages on a stall,
//  flushes IF/ID on a taken branch and counts stall/flush events.
//  Feeds IFID_Rs/IFID_Rt/IDEX_Rt/IDEX_MemRead back to the hazard unit, closing the loop.
// PARAMETERS
//  DATA_W    32   datapath width (PC, instruction, register operands, immediate)
//  CTRL_W    9    width of decoded control bundle carried into EX
//  RESET_PC  0    PC value after reset
//  CNT_W     16   width of stall/flush event counters (saturating)
// PORTS
//  clk           in   1        single clock, all state on rising edge
//  rst_n         in   1        synchronous reset, active low
//  PC_Next       in   DATA_W   next-PC from PC mux (PC+4 or branch target)
//  PC_Write      in   1        from hazard unit; 0 = hold PC
//  IFID_Write    in   1        from hazard unit; 0 = hold IF/ID
//  EX_Bubble     in   1        from hazard unit; 1 = load NOP control into ID/EX
//  Flush         in   1        taken branch resolved in ID; squash IF/ID
//  IF_Instr      in   DATA_W   instruction fetched at PC
//  ID_Ctrl       in   CTRL_W   decoded control for instruction in ID
//  ID_RegA       in   DATA_W   register-file read A
//  ID_RegB       in   DATA_W   register-file read B
//  ID_Imm        in   DATA_W   sign-extended immediate
//  PC            out  DATA_W   current fetch address
//  IFID_Instr    out  DATA_W   latched instruction
//  IFID_PC4      out  DATA_W   latched PC+4
//  IFID_Valid    out  1        IF/ID holds a real instruction
//  IFID_Rs       out  5        IFID_Instr[25:21], to hazard unit
//  IFID_Rt       out  5        IFID_Instr[20:16], to hazard unit
//  IDEX_Ctrl     out  CTRL_W   control bundle in EX
//  IDEX_MemRead  out  1        IDEX_Ctrl[CTRL_MEMREAD], to hazard unit
//  IDEX_Rs/Rt/Rd out  5 each   register specifiers in EX (Rd = instr[15:11])
//  IDEX_RegA/RegB/Imm/PC4 out DATA_W  operands in EX
//  IDEX_Valid    out  1        EX holds a real instruction
//  Stall_Cnt     out  CNT_W    cycles with EX_Bubble=1
//  Flush_Cnt     out  CNT_W    cycles with Flush=1
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): PC=RESET_PC; every other output = 0 (instr 0 = NOP). Valids = 0; counters = 0.
//  - Reset dominates all other inputs, including mid-stall or mid-flush.
//  - Latency: one cycle per stage; an instruction fetched at cycle n appears in IF/ID at n+1 and in ID/EX at n+2.
//  - PC: loads PC_Next when PC_Write=1 or Flush=1; otherwise holds.
//  - IF/ID, priority Flush > hold > load:
//    - Flush=1: Instr=0, PC4=0, Valid=0, even if IFID_Write=0.
//    - Else IFID_Write=0: all IF/ID fields hold.
//    - Else: Instr=IF_Instr, PC4=PC+4 (mod 2^DATA_W), Valid=1.
//  - ID/EX loads every cycle (never held):
//    - EX_Bubble=1: Ctrl=0, Valid=0. Rs/Rt/Rd/RegA/RegB/Imm/PC4 still capture from ID; EX ignores them.
//    - Else: Ctrl=ID_Ctrl, Valid=IFID_Valid, all fields captured.
//    - Flush does not touch ID/EX; the branch in ID has already completed its ID work.
//  - Bubble and stall together: the held IF/ID instruction re-enters ID/EX on the next cycle, and
//    IDEX_MemRead is then 0. A single load-use pair therefore costs exactly one bubble.
//  - Counters: increment by 1 on each edge where the event input is 1; saturate at 2^CNT_W-1, no wrap.
//  - Flush=1 together with EX_Bubble=1: both take effect and both counters increment.
// STRUCTURE
//  - Package pipe_pkg: CTRL_MEMREAD bit index (0); CTRL_MEMWRITE, CTRL_REGWRITE bit indices;
//    NOP_INSTR = 32'h0; field slices RS=[25:21], RT=[20:16], RD=[15:11].
//  - One sub-module: sat_counter (CNT_W, en, clk, rst_n -> count), instantiated twice.
//  - PC, IF/ID and ID/EX are inline always blocks in this module.
// TESTING
//  1 Reset: hold rst_n=0 for 2 cycles with random inputs -> PC=RESET_PC, all other outputs 0.
//  2 Free run, no hazards: PC_Next=PC+4, instructions A,B,C fetched -> A reaches IDEX at cycle 2,
//    IDEX_Valid=1, Stall_Cnt=0.
//  3 Load-use: lw $2 in EX (IDEX_MemRead=1, Rt=2), add $3,$2,$1 in IF/ID.
//    Drive EX_Bubble=1, PC_Write=0, IFID_Write=0 for one cycle ->
//    PC and IFID_Instr unchanged, IDEX_Ctrl=0, IDEX_Valid=0.
//    Next cycle add enters ID/EX; Stall_Cnt=1.
//  4 Flush while stalled: Flush=1, IFID_Write=0, PC_Next=0x100 ->
//    IFID_Instr=0, IFID_Valid=0, PC=0x100, Flush_Cnt=1.
//  5 Saturation: CNT_W=4, EX_Bubble=1 for 20 cycles -> Stall_Cnt=15 and stays 15.
//  6 Reset mid-stall: rst_n=0 while EX_Bubble=1, PC_Write=0 -> next edge PC=RESET_PC,
//    counters 0, valids 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the front-end pipeline registers: control bit positions,
// the NOP encoding and the register-specifier fields of an instruction word.
// Pure definitions; no latency and no flow control.
package pipe_pkg;

  // Bit positions inside the decoded control bundle
  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_REGWRITE = 2;

  // All-zero word decodes as a NOP
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Register-specifier field boundaries
  localparam int REG_W  = 5;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } regspec_t;

  // Pull Rs/Rt/Rd out of an instruction word
  function automatic regspec_t decode_regs(input logic [31:0] instr);
    regspec_t r;
    r.rs = instr[RS_MSB:RS_LSB];
    r.rt = instr[RT_MSB:RT_LSB];
    r.rd = instr[RD_MSB:RD_LSB];
    return r;
  endfunction

endpackage

// File: rtl/stall_pipe_regs_if.sv
// Bundle of hazard-control inputs, ID-stage operands and the PC / IF-ID / ID-EX outputs.
// Wiring only; no latency.
// No backpressure: the hazard unit steers the pipe through PC_Write/IFID_Write/EX_Bubble.
interface stall_pipe_regs_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
);

  // Inputs to the pipeline registers
  logic [DATA_W-1:0] PC_Next;
  logic              PC_Write;
  logic              IFID_Write;
  logic              EX_Bubble;
  logic              Flush;
  logic [DATA_W-1:0] IF_Instr;
  logic [CTRL_W-1:0] ID_Ctrl;
  logic [DATA_W-1:0] ID_RegA;
  logic [DATA_W-1:0] ID_RegB;
  logic [DATA_W-1:0] ID_Imm;

  // Outputs from the pipeline registers
  logic [DATA_W-1:0] PC;
  logic [DATA_W-1:0] IFID_Instr;
  logic [DATA_W-1:0] IFID_PC4;
  logic              IFID_Valid;
  logic [4:0]        IFID_Rs;
  logic [4:0]        IFID_Rt;
  logic [CTRL_W-1:0] IDEX_Ctrl;
  logic              IDEX_MemRead;
  logic [4:0]        IDEX_Rs;
  logic [4:0]        IDEX_Rt;
  logic [4:0]        IDEX_Rd;
  logic [DATA_W-1:0] IDEX_RegA;
  logic [DATA_W-1:0] IDEX_RegB;
  logic [DATA_W-1:0] IDEX_Imm;
  logic [DATA_W-1:0] IDEX_PC4;
  logic              IDEX_Valid;
  logic [CNT_W-1:0]  Stall_Cnt;
  logic [CNT_W-1:0]  Flush_Cnt;

  // Driving side: hazard unit, PC mux, fetch and decode
  modport master (
    output PC_Next, PC_Write, IFID_Write, EX_Bubble, Flush,
           IF_Instr, ID_Ctrl, ID_RegA, ID_RegB, ID_Imm,
    input  PC, IFID_Instr, IFID_PC4, IFID_Valid, IFID_Rs, IFID_Rt,
           IDEX_Ctrl, IDEX_MemRead, IDEX_Rs, IDEX_Rt, IDEX_Rd,
           IDEX_RegA, IDEX_RegB, IDEX_Imm, IDEX_PC4, IDEX_Valid,
           Stall_Cnt, Flush_Cnt
  );

  // Register side: the pipeline state block
  modport slave (
    input  PC_Next, PC_Write, IFID_Write, EX_Bubble, Flush,
           IF_Instr, ID_Ctrl, ID_RegA, ID_RegB, ID_Imm,
    output PC, IFID_Instr, IFID_PC4, IFID_Valid, IFID_Rs, IFID_Rt,
           IDEX_Ctrl, IDEX_MemRead, IDEX_Rs, IDEX_Rt, IDEX_Rd,
           IDEX_RegA, IDEX_RegB, IDEX_Imm, IDEX_PC4, IDEX_Valid,
           Stall_Cnt, Flush_Cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Count reflects an enable one cycle after the edge that sampled it.
// No backpressure; counts every enabled edge.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Increment on enable unless already at the ceiling
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stall_pipe_regs.sv
// PC, IF/ID and ID/EX state steered by the load-use hazard unit; counts bubbles and flushes.
// One cycle per stage: fetched at n -> IF/ID at n+1 -> ID/EX at n+2.
// PC_Write/IFID_Write=0 hold the front stages; EX_Bubble inserts a NOP; ID/EX never holds.
module stall_pipe_regs
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 9,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input logic             clk,
  input logic             rst_n,
  stall_pipe_regs_if.slave bus
);

  // Program counter
  logic [DATA_W-1:0] pc_q, pc_d;

  // IF/ID latch
  logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_W-1:0] ifid_pc4_q, ifid_pc4_d;
  logic              ifid_valid_q, ifid_valid_d;

  // ID/EX latch
  logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
  logic [REG_W-1:0]  idex_rs_q, idex_rs_d;
  logic [REG_W-1:0]  idex_rt_q, idex_rt_d;
  logic [REG_W-1:0]  idex_rd_q, idex_rd_d;
  logic [DATA_W-1:0] idex_rega_q, idex_rega_d;
  logic [DATA_W-1:0] idex_regb_q, idex_regb_d;
  logic [DATA_W-1:0] idex_imm_q, idex_imm_d;
  logic [DATA_W-1:0] idex_pc4_q, idex_pc4_d;
  logic              idex_valid_q, idex_valid_d;

  regspec_t ifid_regs;

  assign ifid_regs = decode_regs(32'(ifid_instr_q));

  // Next PC: a taken branch must redirect fetch even while the hazard unit holds the PC
  always_comb begin
    pc_d = pc_q;
    if (bus.PC_Write || bus.Flush) begin
      pc_d = bus.PC_Next;
    end
  end

  // Next IF/ID: squash beats hold, hold beats load
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (bus.Flush) begin
      ifid_instr_d = DATA_W'(NOP_INSTR);
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (bus.IFID_Write) begin
      ifid_instr_d = bus.IF_Instr;
      ifid_pc4_d   = pc_q + DATA_W'(4);
      ifid_valid_d = 1'b1;
    end
  end

  // Next ID/EX: always captures; a bubble only neutralises control and valid
  always_comb begin
    idex_rs_d    = ifid_regs.rs;
    idex_rt_d    = ifid_regs.rt;
    idex_rd_d    = ifid_regs.rd;
    idex_rega_d  = bus.ID_RegA;
    idex_regb_d  = bus.ID_RegB;
    idex_imm_d   = bus.ID_Imm;
    idex_pc4_d   = ifid_pc4_q;
    idex_ctrl_d  = bus.ID_Ctrl;
    idex_valid_d = ifid_valid_q;
    if (bus.EX_Bubble) begin
      idex_ctrl_d  = '0;
      idex_valid_d = 1'b0;
    end
  end

  // Pipeline state registers; reset overrides stall, flush and bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= DATA_W'(NOP_INSTR);
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      idex_ctrl_q  <= '0;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_rd_q    <= '0;
      idex_rega_q  <= '0;
      idex_regb_q  <= '0;
      idex_imm_q   <= '0;
      idex_pc4_q   <= '0;
      idex_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      idex_ctrl_q  <= idex_ctrl_d;
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
      idex_rd_q    <= idex_rd_d;
      idex_rega_q  <= idex_rega_d;
      idex_regb_q  <= idex_regb_d;
      idex_imm_q   <= idex_imm_d;
      idex_pc4_q   <= idex_pc4_d;
      idex_valid_q <= idex_valid_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (bus.EX_Bubble),
    .count_o(bus.Stall_Cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (bus.Flush),
    .count_o(bus.Flush_Cnt)
  );

  assign bus.PC           = pc_q;
  assign bus.IFID_Instr   = ifid_instr_q;
  assign bus.IFID_PC4     = ifid_pc4_q;
  assign bus.IFID_Valid   = ifid_valid_q;
  assign bus.IFID_Rs      = ifid_regs.rs;
  assign bus.IFID_Rt      = ifid_regs.rt;
  assign bus.IDEX_Ctrl    = idex_ctrl_q;
  assign bus.IDEX_MemRead = idex_ctrl_q[CTRL_MEMREAD];
  assign bus.IDEX_Rs      = idex_rs_q;
  assign bus.IDEX_Rt      = idex_rt_q;
  assign bus.IDEX_Rd      = idex_rd_q;
  assign bus.IDEX_RegA    = idex_rega_q;
  assign bus.IDEX_RegB    = idex_regb_q;
  assign bus.IDEX_Imm     = idex_imm_q;
  assign bus.IDEX_PC4     = idex_pc4_q;
  assign bus.IDEX_Valid   = idex_valid_q;

endmodule
